// File: rtl/instr_sequencer_pkg.sv
// Shared processor definitions: sequencer states, opcode map, error codes
// and the instruction-memory unit select.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_DISPATCH, S_WAIT, S_HALT, S_ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    typedef enum logic [1:0] { CL_MAT, CL_INT, CL_STOP, CL_BAD } op_class_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    localparam logic [3:0] InstrMemEn = 4'h1;

    localparam logic [7:0] MMULT1    = 8'h00;
    localparam logic [7:0] MMULT2    = 8'h01;
    localparam logic [7:0] MMULT3    = 8'h02;
    localparam logic [7:0] MADD      = 8'h03;
    localparam logic [7:0] MSUB      = 8'h04;
    localparam logic [7:0] MTRANS    = 8'h05;
    localparam logic [7:0] MSCALE    = 8'h06;
    localparam logic [7:0] MSCALEIMM = 8'h07;
    localparam logic [7:0] INTADD    = 8'h10;
    localparam logic [7:0] INTSUB    = 8'h11;
    localparam logic [7:0] INTMUL    = 8'h12;
    localparam logic [7:0] INTDIV    = 8'h13;
    localparam logic [7:0] STOP      = 8'hFF;

    function automatic op_class_t classify(input logic [7:0] op);
        if (op >= MMULT1 && op <= MSCALEIMM)
            return CL_MAT;
        else if (op >= INTADD && op <= INTDIV)
            return CL_INT;
        else if (op == STOP)
            return CL_STOP;
        else
            return CL_BAD;
    endfunction

endpackage

// File: rtl/instr_sequencer_watchdog.sv
// 8-bit saturating WAIT-cycle counter; expired flags the cycle whose
// increment would reach the limit.
module seq_watchdog (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] cnt;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            cnt <= 8'd0;
        else if (clear)
            cnt <= 8'd0;
        else if (enable && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

    assign expired = enable && (({1'b0, cnt} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words from ROM, dispatches them to
// the matrix or integer ALU and waits for completion under a watchdog.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [3:0] INSTR_EN = InstrMemEn,
    parameter int         TIMEOUT  = 255
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Start,
    output logic [15:0] address,
    output logic        nRead,
    input  logic [31:0] InstrData,
    output logic [7:0]  Opcode,
    output logic [7:0]  Dest,
    output logic [7:0]  Src1,
    output logic [7:0]  Src2,
    output logic        MatGo,
    output logic        IntGo,
    input  logic        MatDone,
    input  logic        IntDone,
    output logic        Busy,
    output logic        Halted,
    output logic        Error,
    output logic [11:0] Pc,
    output logic [1:0]  ErrCode
);
    localparam logic [7:0] WD_LIMIT = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

    seq_state_t state, nxt;
    instr_t     ir;
    op_class_t  cls;
    logic       is_mat;
    logic       done_hit;
    logic       wd_clr, wd_en, wd_exp;
    logic [11:0] pc_nxt;
    logic [1:0]  err_nxt;

    assign cls      = classify(ir.opcode);
    assign done_hit = is_mat ? MatDone : IntDone;
    assign wd_clr   = (state == S_DISPATCH);
    assign wd_en    = (state == S_WAIT) && !done_hit;

    seq_watchdog u_wd (
        .Clk     (Clk),
        .nReset  (nReset),
        .clear   (wd_clr),
        .enable  (wd_en),
        .limit   (WD_LIMIT),
        .expired (wd_exp)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt     = state;
        pc_nxt  = Pc;
        err_nxt = ErrCode;
        case (state)
            S_IDLE, S_HALT, S_ERROR:
                if (Start) begin
                    nxt     = S_FETCH;
                    pc_nxt  = 12'd0;
                    err_nxt = ERR_NONE;
                end
            S_FETCH:    nxt = S_LATCH;
            S_LATCH:    nxt = S_DECODE;
            S_DECODE:
                case (cls)
                    CL_MAT, CL_INT: nxt = S_DISPATCH;
                    CL_STOP:        nxt = S_HALT;
                    default: begin
                        nxt     = S_ERROR;
                        err_nxt = ERR_ILLEGAL;
                    end
                endcase
            S_DISPATCH: nxt = S_WAIT;
            S_WAIT:
                // a completion on the expiry cycle still counts as success
                if (done_hit) begin
                    pc_nxt = Pc + 12'd1;
                    nxt    = S_FETCH;
                end else if (wd_exp) begin
                    nxt     = S_ERROR;
                    err_nxt = ERR_TIMEOUT;
                end
            default:    nxt = S_IDLE;
        endcase
    end

    // Bus and strobe outputs are registered from the next state.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Pc      <= 12'd0;
            ErrCode <= ERR_NONE;
            ir      <= '0;
            is_mat  <= 1'b0;
            address <= 16'h0;
            nRead   <= 1'b1;
            MatGo   <= 1'b0;
            IntGo   <= 1'b0;
            Busy    <= 1'b0;
            Halted  <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Pc      <= pc_nxt;
            ErrCode <= err_nxt;
            if (state == S_LATCH)
                ir <= InstrData;
            if (state == S_DECODE)
                is_mat <= (cls == CL_MAT);
            nRead   <= (nxt != S_FETCH);
            address <= (nxt == S_FETCH) ? {INSTR_EN, pc_nxt} : 16'h0;
            MatGo   <= (nxt == S_DISPATCH) && (cls == CL_MAT);
            IntGo   <= (nxt == S_DISPATCH) && (cls == CL_INT);
            Busy    <= !(nxt inside {S_IDLE, S_HALT, S_ERROR});
            Halted  <= (nxt == S_HALT);
            Error   <= (nxt == S_ERROR);
        end
    end

    assign Opcode = ir.opcode;
    assign Dest   = ir.dest;
    assign Src1   = ir.src1;
    assign Src2   = ir.src2;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected fetches and dispatches are
// queued as programs are loaded and retired as the DUT emits them.
module tb_instr_sequencer;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Start;
    logic [15:0] address;
    logic        nRead;
    logic [31:0] InstrData;
    logic [7:0]  Opcode, Dest, Src1, Src2;
    logic        MatGo, IntGo, MatDone, IntDone;
    logic        Busy, Halted, Error;
    logic [11:0] Pc;
    logic [1:0]  ErrCode;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rom [4096];

    typedef struct {
        bit          mat;
        logic [31:0] ins;
        logic [11:0] pc;
    } go_t;

    logic [15:0] fq[$];
    go_t         gq[$];

    bit resp_en    = 1'b1;
    bit resp_wrong = 1'b0;
    int resp_dly   = 3;

    always #5 Clk = ~Clk;

    instr_sequencer #(.INSTR_EN(4'h1), .TIMEOUT(4)) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Start     (Start),
        .address   (address),
        .nRead     (nRead),
        .InstrData (InstrData),
        .Opcode    (Opcode),
        .Dest      (Dest),
        .Src1      (Src1),
        .Src2      (Src2),
        .MatGo     (MatGo),
        .IntGo     (IntGo),
        .MatDone   (MatDone),
        .IntDone   (IntDone),
        .Busy      (Busy),
        .Halted    (Halted),
        .Error     (Error),
        .Pc        (Pc),
        .ErrCode   (ErrCode)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM model: data changes on the negedge inside FETCH
    always @(negedge Clk)
        if (!nRead) InstrData = rom[address[11:0]];

    // ALU responder: Done in WAIT cycle resp_dly, optional wrong-unit pulse in WAIT cycle 1
    initial begin
        bit m;
        MatDone = 1'b0;
        IntDone = 1'b0;
        forever begin
            @(negedge Clk);
            MatDone = 1'b0;
            IntDone = 1'b0;
            if (resp_en && (MatGo || IntGo)) begin
                m = MatGo;
                for (int i = 1; i <= resp_dly; i++) begin
                    @(negedge Clk);
                    MatDone = 1'b0;
                    IntDone = 1'b0;
                    if (resp_wrong && i == 1) begin
                        if (m) IntDone = 1'b1; else MatDone = 1'b1;
                    end
                end
                if (m) MatDone = 1'b1; else IntDone = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (nReset) begin
            if (!nRead) begin
                if (fq.size() == 0) chk("fetch_unexp", fq.size(), 1);
                else chk("fetch_addr", address, fq.pop_front());
            end
            if (MatGo || IntGo) begin
                if (gq.size() == 0) chk("go_unexp", gq.size(), 1);
                else begin
                    go_t g;
                    g = gq.pop_front();
                    chk("go_kind", {MatGo, IntGo}, {g.mat, !g.mat});
                    chk("go_op",   Opcode, g.ins[31:24]);
                    chk("go_dest", Dest,   g.ins[23:16]);
                    chk("go_src",  {Src1, Src2}, g.ins[15:0]);
                    chk("go_pc",   Pc, g.pc);
                end
            end
        end
    end

    task automatic push_go(input bit m, input logic [31:0] ins, input logic [11:0] pc);
        go_t g;
        g.mat = m;
        g.ins = ins;
        g.pc  = pc;
        gq.push_back(g);
    endtask

    task automatic start_seq();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (Busy && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_idle_bound", Busy, 0);
    endtask

    task automatic wait_go(input int budget);
        int n = 0;
        while (!(MatGo || IntGo) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_go_bound", MatGo | IntGo, 1);
    endtask

    initial begin
        nReset    = 1'b0;
        Start     = 1'b0;
        InstrData = 32'h0;
        repeat (2) @(negedge Clk);
        chk("rst_addr",  address, 16'h0);
        chk("rst_nread", nRead, 1);
        chk("rst_go",    {MatGo, IntGo}, 0);
        chk("rst_flds",  {Opcode, Dest, Src1, Src2}, 0);
        chk("rst_pc",    Pc, 0);
        chk("rst_stat",  {Busy, Halted, Error, ErrCode}, 0);
        nReset = 1'b1;

        // matrix op then STOP
        rom[0] = 32'h03020001;
        rom[1] = 32'hFF000000;
        fq.push_back(16'h1000);
        push_go(1'b1, rom[0], 12'd0);
        fq.push_back(16'h1001);
        resp_dly = 3;
        start_seq();
        wait_idle(100);
        chk("t1_halted", Halted, 1);
        chk("t1_pc",     Pc, 1);
        chk("t1_err",    Error, 0);

        // integer op, stray MatDone ignored
        rom[0] = 32'h12345678;
        fq.push_back(16'h1000);
        push_go(1'b0, rom[0], 12'd0);
        fq.push_back(16'h1001);
        resp_wrong = 1'b1;
        start_seq();
        chk("t2_halt_clr", Halted, 0);
        wait_go(20);
        repeat (2) @(negedge Clk);
        chk("t2_pc_hold", Pc, 0);
        chk("t2_busy",    Busy, 1);
        wait_idle(100);
        resp_wrong = 1'b0;
        chk("t2_halted", Halted, 1);
        chk("t2_pc",     Pc, 1);

        // illegal opcode, then restart
        rom[0] = 32'h20000000;
        fq.push_back(16'h1000);
        start_seq();
        wait_idle(100);
        chk("t3_err",     Error, 1);
        chk("t3_errcode", ErrCode, 1);
        chk("t3_pc",      Pc, 0);
        chk("t3_halted",  Halted, 0);
        rom[0] = 32'hFF000000;
        fq.push_back(16'h1000);
        start_seq();
        chk("t3_err_clr", {Error, ErrCode}, 0);
        wait_idle(100);
        chk("t3_rs_halt", Halted, 1);
        chk("t3_rs_pc",   Pc, 0);

        // watchdog expiry after four WAIT cycles
        rom[0] = 32'h01000000;
        fq.push_back(16'h1000);
        push_go(1'b1, rom[0], 12'd0);
        resp_en = 1'b0;
        start_seq();
        wait_go(20);
        repeat (4) @(negedge Clk);
        chk("t4_no_err_yet", Error, 0);
        chk("t4_busy_w4",    Busy, 1);
        @(negedge Clk);
        chk("t4_err",     Error, 1);
        chk("t4_errcode", ErrCode, 2);
        chk("t4_pc",      Pc, 0);
        resp_en = 1'b1;

        // Done on the fourth WAIT cycle beats the timeout
        rom[0] = 32'h11000000;
        rom[1] = 32'hFF000000;
        fq.push_back(16'h1000);
        push_go(1'b0, rom[0], 12'd0);
        fq.push_back(16'h1001);
        resp_dly = 4;
        start_seq();
        wait_idle(100);
        chk("t4b_halted", Halted, 1);
        chk("t4b_err",    Error, 0);
        chk("t4b_pc",     Pc, 1);

        // reset mid-WAIT, late Done afterwards
        rom[0] = 32'h05AABBCC;
        fq.push_back(16'h1000);
        push_go(1'b1, rom[0], 12'd0);
        resp_dly = 3;
        start_seq();
        wait_go(20);
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        chk("t5_rst_addr", {address, nRead}, {16'h0, 1'b1});
        chk("t5_rst_go",   {MatGo, IntGo}, 0);
        chk("t5_rst_fld",  {Opcode, Dest, Src1, Src2}, 0);
        chk("t5_rst_stat", {Busy, Halted, Error, ErrCode, Pc}, 0);
        @(negedge Clk);
        nReset = 1'b1;
        repeat (6) @(negedge Clk);
        chk("t5_idle",  {Busy, nRead, Pc}, {1'b0, 1'b1, 12'd0});
        chk("t5_flags", {Halted, Error}, 0);

        // run the full PC range and wrap to 0
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 32'h10000000 | i;
            fq.push_back(16'h1000 | i);
            push_go(1'b0, rom[i], 12'(i));
        end
        fq.push_back(16'h1000);
        resp_dly = 1;
        start_seq();
        begin
            int n = 0;
            while (Pc != 12'd1 && n < 50) begin
                @(negedge Clk);
                n++;
            end
            chk("t6_pc1_bound", Pc, 1);
        end
        rom[0] = 32'hFF000000;
        wait_idle(30000);
        chk("t6_halted", Halted, 1);
        chk("t6_pc",     Pc, 0);

        repeat (4) @(negedge Clk);
        chk("sb_fetch_left", fq.size(), 0);
        chk("sb_go_left",    gq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_EN, default 4'h1, the unit-select value driven on address[15:12] for instruction fetch.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a watchdog error.
REQ-003 SHALL have port Clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-004 SHALL have port nReset, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 SHALL have port Start, input, 1 bit, a one-cycle request to begin execution at PC 0.
REQ-006 SHALL have port address, output, 16 bits, {INSTR_EN, PC} during FETCH and 0 otherwise.
REQ-007 SHALL have port nRead, output, 1 bit, driven low only during FETCH.
REQ-008 SHALL have port InstrData, input, 32 bits, the ROM Dataout, updated on negedge Clk.
REQ-009 SHALL have ports Opcode, Dest, Src1 and Src2, outputs, 8 bits each, the latched instruction fields [31:24], [23:16], [15:8] and [7:0].
REQ-010 SHALL have ports MatGo and IntGo, outputs, 1 bit each, one-cycle dispatch strobes to the matrix ALU and the integer ALU.
REQ-011 SHALL have ports MatDone and IntDone, inputs, 1 bit each, the ALU completion pulses.
REQ-012 SHALL have ports Busy, Halted and Error, outputs, 1 bit each, the status flags; Busy is high in any state other than IDLE, HALT or ERROR.
REQ-013 SHALL have port Pc, output, 12 bits, the current instruction index.
REQ-014 SHALL have port ErrCode, output, 2 bits: 0 = none, 1 = illegal opcode, 2 = timeout.

Function
REQ-015 SHALL implement states IDLE, FETCH, LATCH, DECODE, DISPATCH, WAIT, HALT and ERROR.
REQ-016 SHALL go IDLE -> FETCH on Start=1, with Pc cleared to 0.
REQ-017 SHALL hold FETCH for exactly one cycle with nRead=0 and address={INSTR_EN,Pc}; the ROM updates on the mid-cycle negedge.
REQ-018 SHALL, in LATCH (one cycle, nRead=1), capture InstrData into the four field registers; the fields are held until the next LATCH.
REQ-019 SHALL, in DECODE, classify the opcode: 00h-07h -> matrix; 10h-13h -> integer; FFh -> HALT; any other value -> ERROR with ErrCode=1.
REQ-020 SHALL, in DISPATCH, assert MatGo or IntGo for exactly one cycle according to the class, clear the watchdog counter, then enter WAIT.
REQ-021 SHALL, in WAIT, sample only the Done input that matches the class; the other Done input and any Done seen outside WAIT are ignored.
REQ-022 SHALL, when the matching Done is seen in WAIT, set Pc to Pc+1 modulo 4096 (4095 wraps to 0, no flag) and go to FETCH on the next cycle.
REQ-023 SHALL increment the 8-bit saturating watchdog each WAIT cycle without Done; on reaching TIMEOUT it SHALL go to ERROR with ErrCode=2. A Done arriving on the same cycle as the timeout wins.
REQ-024 SHALL ignore Start while Busy=1.
REQ-025 SHALL, on Start in HALT or ERROR, clear Halted, Error and ErrCode, set Pc=0 and go to FETCH.
REQ-026 SHALL hold Halted=1 in HALT and Error=1 in ERROR.
REQ-027 SHALL keep Pc pointing at the halting or faulting instruction in HALT and ERROR.
REQ-028 SHALL make nRead, address, MatGo, IntGo and Busy registered outputs (no combinational path from inputs).

Reset
REQ-029 SHALL, on nReset=0, immediately force: state IDLE; address=0; nRead=1; MatGo=IntGo=0; Opcode/Dest/Src1/Src2=0; Pc=0; Busy=Halted=Error=0; ErrCode=0; watchdog=0.
REQ-030 SHALL abandon any in-flight operation on reset mid-WAIT, with no strobe re-issued after reset release until a new Start.

Structure
REQ-031 SHALL take the state enum, opcode constants (MMULT1..MSCALEIMM, INTADD..INTDIV, STOP=FFh), the ErrCode enum and InstrMemEn from the shared processor package.
REQ-032 SHALL put the watchdog counter in one sub-module, seq_watchdog (clear, enable, limit, expired).

Verification
REQ-033 SHALL cover: ROM {03020001, FF000000}, Start, MatDone 3 cycles after MatGo -> one MatGo with Dest=02h, then Halted=1 with Pc=1.
REQ-034 SHALL cover: opcode 12h at Pc 0 -> IntGo pulses once and MatGo stays 0; a MatDone pulse in WAIT is ignored; IntDone then advances Pc to 1.
REQ-035 SHALL cover: opcode 20h -> Error=1, ErrCode=1, Pc=0, no Go strobe; a following Start restarts fetch at address 1000h.
REQ-036 SHALL cover: TIMEOUT=4 with no Done -> ERROR with ErrCode=2 after exactly 4 WAIT cycles; Done on the 4th cycle -> advance, no error.
REQ-037 SHALL cover: nReset pulsed low during WAIT -> all outputs at reset values within the same cycle; a late Done after release has no effect.
REQ-038 SHALL cover: Pc forced to 4095 with a non-stop instruction completing -> next fetch address=1000h (Pc wraps to 0).
